// File: rtl/psk_tx_packetizer_if.sv
// psk_tx_packetizer_if -- AXI-Stream byte channel feeding the PSK transmit framer.
// Rev 1.0
`default_nettype none

interface psk_tx_packetizer_if;
  logic [7:0] data_tdata;
  logic       data_tvalid;
  logic       data_tready;
  logic       data_tlast;

  modport master (
    output data_tdata,
    output data_tvalid,
    output data_tlast,
    input  data_tready
  );

  modport slave (
    input  data_tdata,
    input  data_tvalid,
    input  data_tlast,
    output data_tready
  );
endinterface

`default_nettype wire

// File: rtl/psk_tx_packetizer.sv
// psk_tx_packetizer -- PSK frame builder: preamble, Barker-13 sync, payload, tail.
// Rev 1.0
`default_nettype none

module psk_tx_packetizer #(
  parameter int          PREAMBLE_LEN = 32,
  parameter int          TAIL_LEN     = 8,
  parameter logic [12:0] SYNC_WORD    = 13'b1111100110101
) (
  input  logic                 clk_32M768,
  input  logic                 rst_32M768,
  input  logic                 clk_enable,
  input  logic [3:0]           MODE_CTRL,
  psk_tx_packetizer_if.slave   data,
  output logic                 BPSK,
  output logic [1:0]           QPSK,
  output logic                 sym_valid,
  output logic                 is_bpsk,
  output logic                 tx_active,
  output logic                 underrun
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] TAIL_END = 8'(TAIL_LEN);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SYNC     = 3'd2,
    PAYLOAD  = 3'd3,
    TAIL     = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       tlast_q, tlast_nxt;
  logic       bpsk_nxt, valid_nxt, mode_nxt, underrun_nxt;
  logic [1:0] qpsk_nxt;
  logic       sym_last, load_pt, sync_bit;
  logic       unused_mode;

  assign unused_mode = ^MODE_CTRL[3:1];

  // cnt tracks the symbol the next strobe emits, so load points are known before the edge
  assign sym_last = is_bpsk ? (cnt[2:0] == 3'd7) : (cnt[1:0] == 2'd3);
  assign load_pt  = ((state == SYNC) && (cnt == 8'd0)) ||
                    ((state == PAYLOAD) && sym_last && !tlast_q);
  assign sync_bit = SYNC_WORD[cnt[3:0]];

  assign data.data_tready = clk_enable & load_pt & ~rst_32M768;
  assign tx_active        = (state != IDLE);

  always_ff @(posedge clk_32M768) begin
    if (rst_32M768) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      shreg     <= 8'd0;
      tlast_q   <= 1'b0;
      BPSK      <= 1'b0;
      QPSK      <= 2'b00;
      sym_valid <= 1'b0;
      is_bpsk   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      tlast_q   <= tlast_nxt;
      BPSK      <= bpsk_nxt;
      QPSK      <= qpsk_nxt;
      sym_valid <= valid_nxt;
      is_bpsk   <= mode_nxt;
      underrun  <= underrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    tlast_nxt    = tlast_q;
    bpsk_nxt     = BPSK;
    qpsk_nxt     = QPSK;
    valid_nxt    = sym_valid;
    mode_nxt     = is_bpsk;
    underrun_nxt = 1'b0;

    if (clk_enable) begin
      case (state)
        IDLE: begin
          if (data.data_tvalid) begin
            mode_nxt  = MODE_CTRL[0];
            bpsk_nxt  = 1'b1;
            qpsk_nxt  = 2'b11;
            valid_nxt = 1'b1;
            if (PRE_LAST == 8'd0) begin
              state_nxt = SYNC;
              cnt_nxt   = 8'd12;
            end else begin
              state_nxt = PREAMBLE;
              cnt_nxt   = 8'd1;
            end
          end else begin
            bpsk_nxt  = 1'b0;
            qpsk_nxt  = 2'b00;
            valid_nxt = 1'b0;
          end
        end

        PREAMBLE: begin
          bpsk_nxt  = ~cnt[0];
          qpsk_nxt  = {2{~cnt[0]}};
          valid_nxt = 1'b1;
          if (cnt == PRE_LAST) begin
            state_nxt = SYNC;
            cnt_nxt   = 8'd12;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end

        SYNC: begin
          bpsk_nxt  = sync_bit;
          qpsk_nxt  = {2{sync_bit}};
          valid_nxt = 1'b1;
          if (cnt == 8'd0) begin
            if (data.data_tvalid) begin
              shreg_nxt = data.data_tdata;
              tlast_nxt = data.data_tlast;
              state_nxt = PAYLOAD;
            end else begin
              underrun_nxt = 1'b1;
              state_nxt    = TAIL;
            end
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end

        PAYLOAD: begin
          valid_nxt = 1'b1;
          if (is_bpsk) begin
            bpsk_nxt  = shreg[7];
            qpsk_nxt  = {2{shreg[7]}};
            shreg_nxt = {shreg[6:0], 1'b0};
          end else begin
            bpsk_nxt  = 1'b0;
            qpsk_nxt  = shreg[7:6];
            shreg_nxt = {shreg[5:0], 2'b00};
          end
          if (sym_last) begin
            cnt_nxt = 8'd0;
            if (tlast_q) begin
              state_nxt = (TAIL_END == 8'd0) ? IDLE : TAIL;
            end else if (data.data_tvalid) begin
              shreg_nxt = data.data_tdata;
              tlast_nxt = data.data_tlast;
            end else begin
              underrun_nxt = 1'b1;
              state_nxt    = TAIL;
            end
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end

        TAIL: begin
          bpsk_nxt = 1'b0;
          qpsk_nxt = 2'b00;
          // one extra strobe with sym_valid low guarantees an idle gap between frames
          if (cnt == TAIL_END) begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
          end else begin
            valid_nxt = 1'b1;
            cnt_nxt   = cnt + 8'd1;
          end
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // load_pt is consumed by data_tready; keep lint quiet about partial cnt use
  logic unused_cnt;
  assign unused_cnt = ^cnt[7:4] & load_pt & 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_psk_tx_packetizer.sv
// tb_psk_tx_packetizer -- directed frame-level checks of the PSK transmit framer.
// Rev 1.0
`default_nettype none

`define CHK(TAG, OBS, EXP) begin compares++; assert ((OBS) === (EXP)) else begin fails++; $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); end end

module tb_psk_tx_packetizer;
  logic       clk_32M768 = 1'b0;
  logic       rst_32M768;
  logic       clk_enable;
  logic [3:0] MODE_CTRL;
  logic       BPSK;
  logic [1:0] QPSK;
  logic       sym_valid, is_bpsk, tx_active, underrun;

  int compares = 0;
  int fails    = 0;

  psk_tx_packetizer_if bus ();

  psk_tx_packetizer #(
    .PREAMBLE_LEN (4),
    .TAIL_LEN     (2),
    .SYNC_WORD    (13'b1111100110101)
  ) dut (
    .clk_32M768 (clk_32M768),
    .rst_32M768 (rst_32M768),
    .clk_enable (clk_enable),
    .MODE_CTRL  (MODE_CTRL),
    .data       (bus),
    .BPSK       (BPSK),
    .QPSK       (QPSK),
    .sym_valid  (sym_valid),
    .is_bpsk    (is_bpsk),
    .tx_active  (tx_active),
    .underrun   (underrun)
  );

  always #15 clk_32M768 = ~clk_32M768;

  // One symbol strobe; tready is sampled while the strobe is high, underrun right after it
  task automatic strobe(output logic rdy, output logic und, output logic und_after);
    @(negedge clk_32M768);
    clk_enable = 1'b1;
    #1 rdy = bus.data_tready;
    @(posedge clk_32M768);
    #1 clk_enable = 1'b0;
    und = underrun;
    @(posedge clk_32M768);
    #1 und_after = underrun;
    @(posedge clk_32M768);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk_32M768);
    rst_32M768 = 1'b1;
    @(posedge clk_32M768);
    #1 rst_32M768 = 1'b0;
  endtask

  initial begin
    logic        rdy, und, und_a;
    logic [26:0] exp1, exp3, exp4;
    logic [53:0] exp2;
    int          bad;

    exp1 = {4'b1010, 13'b1111100110101, 8'b10100101, 2'b00};
    exp2 = {8'b11001100, 26'b11111111110000111100110011, 16'b0001101111100100, 4'b0000};
    exp3 = {4'b1010, 13'b1111100110101, 8'b00111100, 2'b00};
    exp4 = {4'b1010, 13'b1111100110101, 8'b10010110, 2'b00};

    rst_32M768      = 1'b1;
    clk_enable      = 1'b0;
    MODE_CTRL       = 4'h0;
    bus.data_tdata  = 8'h00;
    bus.data_tvalid = 1'b0;
    bus.data_tlast  = 1'b0;
    repeat (3) @(posedge clk_32M768);
    #1 rst_32M768 = 1'b0;

    `CHK("rst_bpsk", BPSK, 1'b0)
    `CHK("rst_qpsk", QPSK, 2'b00)
    `CHK("rst_valid", sym_valid, 1'b0)
    `CHK("rst_is_bpsk", is_bpsk, 1'b0)
    `CHK("rst_active", tx_active, 1'b0)
    `CHK("rst_underrun", underrun, 1'b0)
    `CHK("rst_tready", bus.data_tready, 1'b0)

    // BPSK single byte 0xA5 with tlast
    MODE_CTRL = 4'h1; bus.data_tdata = 8'hA5; bus.data_tlast = 1'b1; bus.data_tvalid = 1'b1;
    for (int i = 0; i < 28; i++) begin
      strobe(rdy, und, und_a);
      if (rdy && bus.data_tvalid) bus.data_tvalid = 1'b0;
      if (i < 27) `CHK("t1_bpsk", BPSK, exp1[26-i])
      `CHK("t1_valid", sym_valid, (i < 27))
      `CHK("t1_tready", rdy, (i == 16))
      `CHK("t1_active", tx_active, (i < 27))
      if (i == 0) `CHK("t1_is_bpsk", is_bpsk, 1'b1)
    end

    // QPSK two bytes 0x1B, 0xE4(tlast)
    MODE_CTRL = 4'hE; bus.data_tdata = 8'h1B; bus.data_tlast = 1'b0; bus.data_tvalid = 1'b1;
    for (int i = 0; i < 28; i++) begin
      strobe(rdy, und, und_a);
      if (rdy && i == 16) begin bus.data_tdata = 8'hE4; bus.data_tlast = 1'b1; end
      if (rdy && i == 20) bus.data_tvalid = 1'b0;
      if (i < 27) `CHK("t2_qpsk", QPSK, exp2[2*(26-i)+1 -: 2])
      if (i >= 17 && i < 25) `CHK("t2_bpsk_zero", BPSK, 1'b0)
      `CHK("t2_valid", sym_valid, (i < 27))
      `CHK("t2_tready", rdy, (i == 16 || i == 20))
      if (i == 0) `CHK("t2_is_bpsk", is_bpsk, 1'b0)
    end

    // Underrun after the first byte of a two-byte BPSK packet
    MODE_CTRL = 4'h1; bus.data_tdata = 8'h3C; bus.data_tlast = 1'b0; bus.data_tvalid = 1'b1;
    for (int i = 0; i < 28; i++) begin
      strobe(rdy, und, und_a);
      if (rdy && bus.data_tvalid) bus.data_tvalid = 1'b0;
      if (i < 27) `CHK("t3_bpsk", BPSK, exp3[26-i])
      `CHK("t3_valid", sym_valid, (i < 27))
      `CHK("t3_underrun", und, (i == 24))
      `CHK("t3_underrun_1cyc", und_a, 1'b0)
      `CHK("t3_tready", rdy, (i == 16 || i == 24))
    end
    `CHK("t3_idle", tx_active, 1'b0)

    // Mode change mid-payload: frame stays BPSK
    MODE_CTRL = 4'h1; bus.data_tdata = 8'h96; bus.data_tlast = 1'b1; bus.data_tvalid = 1'b1;
    for (int i = 0; i < 28; i++) begin
      strobe(rdy, und, und_a);
      if (rdy && bus.data_tvalid) bus.data_tvalid = 1'b0;
      if (i == 18) MODE_CTRL = 4'h0;
      if (i < 27) `CHK("t4_bpsk", BPSK, exp4[26-i])
      if (i < 27) `CHK("t4_is_bpsk", is_bpsk, 1'b1)
      `CHK("t4_valid", sym_valid, (i < 27))
    end

    // Next frame picks up the new mode
    bus.data_tdata = 8'h55; bus.data_tlast = 1'b1; bus.data_tvalid = 1'b1;
    strobe(rdy, und, und_a);
    `CHK("t5_is_bpsk", is_bpsk, 1'b0)
    `CHK("t5_qpsk0", QPSK, 2'b11)
    `CHK("t5_valid", sym_valid, 1'b1)
    strobe(rdy, und, und_a);
    `CHK("t5_qpsk1", QPSK, 2'b00)
    pulse_reset();

    // BPSK frame reset while in SYNC, between strobes
    MODE_CTRL = 4'h1;
    for (int i = 0; i < 8; i++) strobe(rdy, und, und_a);
    `CHK("t6_pre_active", tx_active, 1'b1)
    `CHK("t6_pre_is_bpsk", is_bpsk, 1'b1)
    `CHK("t6_pre_sync_bit", BPSK, 1'b1)
    pulse_reset();
    `CHK("t6_bpsk", BPSK, 1'b0)
    `CHK("t6_qpsk", QPSK, 2'b00)
    `CHK("t6_valid", sym_valid, 1'b0)
    `CHK("t6_is_bpsk", is_bpsk, 1'b0)
    `CHK("t6_active", tx_active, 1'b0)
    `CHK("t6_underrun", underrun, 1'b0)
    strobe(rdy, und, und_a);
    `CHK("t6_restart_bpsk", BPSK, 1'b1)
    `CHK("t6_restart_valid", sym_valid, 1'b1)
    `CHK("t6_restart_is_bpsk", is_bpsk, 1'b1)
    `CHK("t6_restart_active", tx_active, 1'b1)
    strobe(rdy, und, und_a);
    `CHK("t6_restart_sym1", BPSK, 1'b0)
    pulse_reset();

    // tvalid held without strobes: nothing may move
    bus.data_tvalid = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_32M768);
      if (bus.data_tready !== 1'b0 || sym_valid !== 1'b0 || tx_active !== 1'b0) bad++;
    end
    `CHK("t7_gated_cycles", bad, 0)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

`undef CHK

`default_nettype wire

// File: doc/psk_tx_packetizer.md
# psk_tx_packetizer

Transmit-side framer for the PSK link. It takes a byte stream over AXI-Stream and emits one symbol per recovered-rate strobe. Each frame is a timing preamble, a Barker-13 sync word, the payload bits and a tail. This matches the receive chain's SD/PD/BD detectors and depacketizer. The block sits between the byte source and the PSK modulator/DAC path in the 32.768 MHz domain.

## Interface
Parameters:
- PREAMBLE_LEN, 32: preamble length in symbols, 1..255.
- TAIL_LEN, 8: tail length in symbols, 0..255.
- SYNC_WORD, 13'b1111100110101: Barker-13 pattern, sent MSB first.

Ports:
- clk_32M768, in, 1: the only clock.
- rst_32M768, in, 1: synchronous, active-high reset.
- clk_enable, in, 1: symbol strobe. One-cycle pulse per symbol (1.024 MHz).
- MODE_CTRL, in, 4: bit0 = 1 selects BPSK, bit0 = 0 selects QPSK. Bits 3:1 are ignored.
- data_tdata, in, 8: payload byte.
- data_tvalid, in, 1: AXI-Stream valid.
- data_tready, out, 1: AXI-Stream ready.
- data_tlast, in, 1: marks the final byte of the packet.
- BPSK, out, 1: current BPSK symbol bit.
- QPSK, out, 2: current QPSK symbol, {I bit, Q bit}.
- sym_valid, out, 1: high while a frame symbol is on BPSK/QPSK.
- is_bpsk, out, 1: mode latched for the current frame.
- tx_active, out, 1: high whenever the state is not IDLE.
- underrun, out, 1: one-cycle pulse when a payload byte was needed and none was available.

## Operation
The state machine has five states: IDLE, PREAMBLE, SYNC, PAYLOAD and TAIL. All state changes and output updates happen only on clk_32M768 cycles where clk_enable = 1.

- **IDLE**
  - On a strobe with data_tvalid = 1: latch is_bpsk = MODE_CTRL[0], emit preamble symbol 0 and go to PREAMBLE.
  - Otherwise: sym_valid = 0, BPSK = 0, QPSK = 0.
- **PREAMBLE**
  - Symbol k is k[0] ^ 1, i.e. 1,0,1,0,...
  - BPSK gets that bit; QPSK gets {b,b}.
  - The state lasts PREAMBLE_LEN strobes, counting the IDLE-exit strobe. Then go to SYNC.
- **SYNC**
  - Emit SYNC_WORD bits 12 down to 0, one per strobe, in both modes (QPSK = {b,b}).
  - On the strobe that emits bit 0, pulse data_tready.
    - If data_tvalid = 1: load data_tdata into the shift register, latch data_tlast, go to PAYLOAD.
    - If data_tvalid = 0: pulse underrun and go to TAIL.
- **PAYLOAD**
  - BPSK mode: emit byte bits 7 down to 0, 8 strobes per byte.
  - QPSK mode: emit {b7,b6}, {b5,b4}, {b3,b2}, {b1,b0}, 4 strobes per byte. BPSK output is 0.
  - On the strobe that emits the last symbol of a byte:
    - If the latched tlast = 1: go to TAIL, or to IDLE when TAIL_LEN = 0. data_tready stays low.
    - Otherwise: pulse data_tready and load the next byte. With no data_tvalid, pulse underrun and go to TAIL.
- **TAIL**
  - Emit TAIL_LEN symbols of 0 with sym_valid = 1.
  - Then go to IDLE. sym_valid falls on the strobe after the last tail symbol.
- **General rules**
  - data_tready = clk_enable AND (load point as defined above). It is combinational from the registered state. A transfer happens only when data_tvalid = data_tready = 1 in the same cycle.
  - data_tready is never high in IDLE, PREAMBLE or TAIL. data_tready and underrun never assert in the same cycle.
  - MODE_CTRL changes mid-frame are ignored until the next IDLE exit.
  - Frame length in strobes: BPSK = PREAMBLE_LEN + 13 + 8N + TAIL_LEN; QPSK = PREAMBLE_LEN + 13 + 4N + TAIL_LEN, where N = bytes up to and including tlast.
  - A single-byte packet (tlast on the first byte) is legal.

## Timing
- **Reset** (rst_32M768 = 1 at a clock edge, regardless of clk_enable):
  - State goes to IDLE and all counters clear.
  - BPSK = 0, QPSK = 0, sym_valid = 0, is_bpsk = 0, tx_active = 0, underrun = 0, data_tready = 0.
  - A partially sent frame is dropped. The first strobe after reset release may start a new frame.
- **Output latency**: BPSK, QPSK, sym_valid, is_bpsk and tx_active are registered. They change in the cycle after the strobe edge and hold until the next strobe.
- **underrun**: registered. It is high for exactly one clk_32M768 cycle after the strobe that detected the missing byte.
- **data_tvalid checks**: data_tvalid is sampled only on strobe cycles. data_tvalid without a strobe has no effect.
- **Back-to-back frames**: the strobe that leaves TAIL lands in IDLE. The next frame can start on the following strobe, so at least one idle symbol (sym_valid = 0) separates frames.

## Test plan
- **BPSK single byte.** PREAMBLE_LEN = 4, TAIL_LEN = 2, MODE_CTRL = 1, byte 0xA5 with tlast.
  - BPSK sequence: 1,0,1,0, then 1111100110101, then 10100101, then 0,0. That is 27 symbols with sym_valid = 1.
  - data_tready pulses exactly once, on the 17th strobe.
- **QPSK two bytes.** MODE_CTRL = 0, bytes 0x1B then 0xE4 (tlast), PREAMBLE_LEN = 4, TAIL_LEN = 2.
  - Payload QPSK: 00,01,10,11,11,10,01,00.
  - Sync sent as {b,b}. Total 27 strobes.
  - data_tready pulses twice, 4 strobes apart.
- **Underrun.** BPSK, two-byte packet, but tvalid drops after byte 1.
  - underrun pulses on the 8th payload strobe, then TAIL_LEN zeros, then IDLE.
- **Mode change mid-frame.** MODE_CTRL switches 1 → 0 during PAYLOAD.
  - is_bpsk stays 1 and the frame finishes in BPSK.
  - The next frame starts with is_bpsk = 0.
- **Reset mid-frame.** Assert rst_32M768 for 1 cycle during SYNC with no strobe.
  - All outputs are 0 the next cycle. A new frame starts from preamble symbol 0.
- **Strobe gating.** Hold tvalid with clk_enable = 0 for 100 cycles.
  - No state change. data_tready stays 0 and sym_valid stays 0.
